// File: rtl/writeback_queue.sv
// In-order write-back FIFO feeding the 16 x 32-bit register bank, with read-port hazard detection.
// Optional data forwarding to the read ports is built only when WB_BYPASS_EN is defined.
module writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [ADDR_W-1:0]          alu_dest,
   input  logic [DATA_W-1:0]          alu_data,
   input  logic                       ldr_valid,
   output logic                       ldr_ready,
   input  logic [ADDR_W-1:0]          ldr_dest,
   input  logic [DATA_W-1:0]          ldr_data,
   input  logic                       wb_hold,
   output logic                       rf_we,
   output logic [ADDR_W-1:0]          rf_dest,
   output logic [DATA_W-1:0]          rf_data,
   input  logic [ADDR_W-1:0]          src1_sel,
   input  logic [ADDR_W-1:0]          src2_sel,
   output logic                       src1_pending,
   output logic                       src2_pending,
   output logic                       src1_fwd_valid,
   output logic                       src2_fwd_valid,
   output logic [DATA_W-1:0]          src1_fwd_data,
   output logic [DATA_W-1:0]          src2_fwd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] dest_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0]  head_reg, tail_reg;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              rf_we_reg;
   logic [ADDR_W-1:0] rf_dest_reg;
   logic [DATA_W-1:0] rf_data_reg;

   logic              push_ldr, push_alu, push, drain;
   logic [ADDR_W-1:0] push_dest;
   logic [DATA_W-1:0] push_data;

   assign full      = (count_reg == CNT_W'(DEPTH));
   assign empty     = (count_reg == '0);
   assign count     = count_reg;

   // Readiness looks at full only, so a same-cycle drain never frees a slot early.
   assign ldr_ready = !full;
   assign alu_ready = !full && !ldr_valid;

   assign push_ldr  = ldr_valid && ldr_ready;
   assign push_alu  = alu_valid && alu_ready;
   assign push      = push_ldr || push_alu;
   assign push_dest = push_ldr ? ldr_dest : alu_dest;
   assign push_data = push_ldr ? ldr_data : alu_data;
   assign drain     = !empty && !wb_hold;

   always_comb begin
      count_next = count_reg;
      if (push && !drain)
         count_next = count_reg + CNT_W'(1);
      else if (!push && drain)
         count_next = count_reg - CNT_W'(1);
   end

   // Storage is not reset; occupancy is defined solely by head_reg/count_reg.
   always_ff @(posedge clk) begin
      if (push) begin
         dest_mem[tail_reg] <= push_dest;
         data_mem[tail_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg    <= '0;
         tail_reg    <= '0;
         count_reg   <= '0;
         rf_we_reg   <= 1'b0;
         rf_dest_reg <= '0;
         rf_data_reg <= '0;
      end else begin
         count_reg <= count_next;
         rf_we_reg <= drain;
         if (push)
            tail_reg <= tail_reg + PTR_W'(1);
         if (drain) begin
            head_reg    <= head_reg + PTR_W'(1);
            rf_dest_reg <= dest_mem[head_reg];
            rf_data_reg <= data_mem[head_reg];
         end
      end
   end

   assign rf_we   = rf_we_reg;
   assign rf_dest = rf_dest_reg;
   assign rf_data = rf_data_reg;

   // Entries are examined in age order: slot gi is the gi-th oldest occupied entry.
   logic [DEPTH-1:0][PTR_W-1:0] age_idx;
   logic [DEPTH-1:0]            age_live;
   logic [DEPTH-1:0]            src1_hit, src2_hit;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_age
         assign age_idx[gi]  = head_reg + PTR_W'(gi);
         assign age_live[gi] = (CNT_W'(gi) < count_reg);
         assign src1_hit[gi] = age_live[gi] && (dest_mem[age_idx[gi]] == src1_sel);
         assign src2_hit[gi] = age_live[gi] && (dest_mem[age_idx[gi]] == src2_sel);
      end
   endgenerate

   assign src1_pending = |src1_hit;
   assign src2_pending = |src2_hit;

`ifdef WB_BYPASS_EN
   // Scanning oldest to youngest lets the youngest match win.
   always_comb begin
      src1_fwd_data = '0;
      src2_fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (src1_hit[k])
            src1_fwd_data = data_mem[age_idx[k]];
         if (src2_hit[k])
            src2_fwd_data = data_mem[age_idx[k]];
      end
   end

   assign src1_fwd_valid = src1_pending;
   assign src2_fwd_valid = src2_pending;
`else
   assign src1_fwd_valid = 1'b0;
   assign src2_fwd_valid = 1'b0;
   assign src1_fwd_data  = '0;
   assign src2_fwd_data  = '0;
`endif

endmodule
